// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - two-port round-robin arbiter sharing the L2 port between I-cache and D-cache
module l2_arbiter #(
  parameter int width      = 128,
  parameter int addr_width = 16,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_pmem_read,
  input  logic [addr_width-1:0] icache_pmem_address,
  output logic [width-1:0]      icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [addr_width-1:0] dcache_pmem_address,
  input  logic [width-1:0]      dcache_pmem_wdata,
  output logic [width-1:0]      dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [addr_width-1:0] l2_address,
  output logic [width-1:0]      l2_wdata,
  input  logic [width-1:0]      l2_rdata,
  input  logic                  l2_resp,
  output logic                  last_grant,
  output logic [cnt_width-1:0]  icache_grant_count,
  output logic [cnt_width-1:0]  dcache_grant_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic [cnt_width-1:0] cnt_max = {cnt_width{1'b1}};
  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       i_req;
  logic       d_req;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // Line data is broadcast to both L1s; only the resp pulse qualifies it.
  assign icache_pmem_rdata = l2_rdata;
  assign dcache_pmem_rdata = l2_rdata;

  // Arbitrate in IDLE (ties go to the port not served last); hold a grant until l2_resp
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          next_state = last_grant ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          next_state = SERVE_I;
        end else if (d_req) begin
          next_state = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Steer the granted port's operands onto the L2 port and route l2_resp back to it
  always_comb begin
    l2_read          = 1'b0;
    l2_write         = 1'b0;
    l2_address       = '0;
    l2_wdata         = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      SERVE_I: begin
        l2_read          = 1'b1;
        l2_address       = icache_pmem_address;
        icache_pmem_resp = l2_resp;
      end
      SERVE_D: begin
        // Simultaneous read and write is illegal; read wins.
        l2_read          = dcache_pmem_read;
        l2_write         = dcache_pmem_write & ~dcache_pmem_read;
        l2_address       = dcache_pmem_address;
        l2_wdata         = dcache_pmem_wdata;
        dcache_pmem_resp = l2_resp;
      end
      default: ;
    endcase
  end

  // State, round-robin history and saturating per-port completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= 1'b0;
      icache_grant_count <= '0;
      dcache_grant_count <= '0;
    end else begin
      state <= next_state;
      if (state == SERVE_I && l2_resp) begin
        last_grant <= 1'b0;
        if (icache_grant_count != cnt_max) begin
          icache_grant_count <= icache_grant_count + cnt_one;
        end
      end
      if (state == SERVE_D && l2_resp) begin
        last_grant <= 1'b1;
        if (dcache_grant_count != cnt_max) begin
          dcache_grant_count <= dcache_grant_count + cnt_one;
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - scoreboard testbench for l2_arbiter
module tb_l2_arbiter;

  localparam int W  = 128;
  localparam int AW = 16;
  localparam int CW = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [W-1:0]  icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [W-1:0]  dcache_pmem_wdata;
  logic [W-1:0]  dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [W-1:0]  l2_wdata;
  logic [W-1:0]  l2_rdata;
  logic          l2_resp;
  logic          last_grant;
  logic [CW-1:0] icache_grant_count;
  logic [CW-1:0] dcache_grant_count;

  logic [W-1:0]  s_icache_pmem_rdata;
  logic          s_icache_pmem_resp;
  logic [W-1:0]  s_dcache_pmem_rdata;
  logic          s_dcache_pmem_resp;
  logic          s_l2_read;
  logic          s_l2_write;
  logic [AW-1:0] s_l2_address;
  logic [W-1:0]  s_l2_wdata;
  logic          s_last_grant;
  logic [SW-1:0] s_icache_grant_count;
  logic [SW-1:0] s_dcache_grant_count;

  l2_arbiter #(.width(W), .addr_width(AW), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .last_grant(last_grant),
    .icache_grant_count(icache_grant_count), .dcache_grant_count(dcache_grant_count)
  );

  // Narrow-counter copy on the same inputs exercises the saturation boundary quickly.
  l2_arbiter #(.width(W), .addr_width(AW), .cnt_width(SW)) dut_sat (
    .clk(clk), .reset(reset),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(s_icache_pmem_rdata), .icache_pmem_resp(s_icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(s_dcache_pmem_rdata), .dcache_pmem_resp(s_dcache_pmem_resp),
    .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_address(s_l2_address), .l2_wdata(s_l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .last_grant(s_last_grant),
    .icache_grant_count(s_icache_grant_count), .dcache_grant_count(s_dcache_grant_count)
  );

  typedef struct {
    bit            port;
    logic [AW-1:0] addr;
    bit            wr;
    logic [W-1:0]  data;
  } txn_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            wr;
    logic [W-1:0]  wdata;
  } req_t;

  txn_t sb[$];
  req_t iq[$];
  req_t dq[$];
  int   i_idx = 0;
  int   d_idx = 0;
  int   i_resp_n = 0;
  int   d_resp_n = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   lat = 2;
  bit   l2_en = 1'b1;
  int   stray_req = 0;
  int   stray_done = 0;
  int   d_skip = 0;
  int   d_skipped = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 16'h1230) return 128'hDEAD_C0DE_0123_4567_89AB_CDEF_FACE_BEEF;
    return {8{a ^ 16'hC3A5}};
  endfunction

  // Monitor on negedge, then L2 model and L1 requesters driven just after posedge
  initial begin : bus
    int   lat_cnt;
    bit   i_done_now;
    bit   d_done_now;
    txn_t e;
    lat_cnt = 0;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    forever begin
      @(negedge clk);
      i_done_now = 1'b0;
      d_done_now = 1'b0;
      if (l2_read)  rd_cycles++;
      if (l2_write) wr_cycles++;
      if (icache_pmem_resp || dcache_pmem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b want none", icache_pmem_resp, dcache_pmem_resp);
        end else begin
          e = sb.pop_front();
          checks++;
          if ({icache_pmem_resp, dcache_pmem_resp} !== (e.port ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL resp_port: got %b want %b", {icache_pmem_resp, dcache_pmem_resp}, (e.port ? 2'b01 : 2'b10));
          end
          checks++;
          if (l2_address !== e.addr) begin
            errors++;
            $display("FAIL l2_address: got %h want %h", l2_address, e.addr);
          end
          checks++;
          if ({l2_read, l2_write} !== (e.wr ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL l2_strobe: got %b want %b", {l2_read, l2_write}, (e.wr ? 2'b01 : 2'b10));
          end
          checks++;
          if (e.wr) begin
            if (l2_wdata !== e.data) begin
              errors++;
              $display("FAIL l2_wdata: got %h want %h", l2_wdata, e.data);
            end
          end else if ((e.port ? dcache_pmem_rdata : icache_pmem_rdata) !== e.data) begin
            errors++;
            $display("FAIL rdata: got %h want %h", (e.port ? dcache_pmem_rdata : icache_pmem_rdata), e.data);
          end
        end
        i_done_now = icache_pmem_resp;
        d_done_now = dcache_pmem_resp;
      end

      @(posedge clk);
      #1;
      if (i_done_now) begin i_resp_n++; i_idx++; end
      if (d_done_now) begin d_resp_n++; d_idx++; end
      if (d_skip != d_skipped) begin d_skipped++; d_idx++; end

      if (l2_resp) begin
        l2_resp = 1'b0;
        lat_cnt = 0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        l2_resp  = 1'b1;
        l2_rdata = {4{32'h5555_AAAA}};
      end else if (l2_en && (l2_read || l2_write)) begin
        lat_cnt++;
        if (lat_cnt >= lat) begin
          l2_resp  = 1'b1;
          l2_rdata = rd_model(l2_address);
          lat_cnt  = 0;
        end
      end else begin
        lat_cnt = 0;
      end

      if (i_idx < iq.size()) begin
        icache_pmem_read    = 1'b1;
        icache_pmem_address = iq[i_idx].addr;
      end else begin
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
      end
      if (d_idx < dq.size()) begin
        dcache_pmem_read    = !dq[d_idx].wr;
        dcache_pmem_write   = dq[d_idx].wr;
        dcache_pmem_address = dq[d_idx].addr;
        dcache_pmem_wdata   = dq[d_idx].wdata;
      end else begin
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (i_idx >= iq.size() && d_idx >= dq.size() && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got pending i=%0d d=%0d sb=%0d want all done", name,
               iq.size() - i_idx, dq.size() - d_idx, sb.size());
    end
  endtask

  task automatic push_i(input logic [AW-1:0] a);
    iq.push_back('{addr: a, wr: 1'b0, wdata: '0});
    sb.push_back('{port: 1'b0, addr: a, wr: 1'b0, data: rd_model(a)});
  endtask

  task automatic push_d(input logic [AW-1:0] a, input bit wr, input logic [W-1:0] wd, input bit expect_sb);
    dq.push_back('{addr: a, wr: wr, wdata: wd});
    if (expect_sb) sb.push_back('{port: 1'b1, addr: a, wr: wr, data: (wr ? wd : rd_model(a))});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp});
    end
    checks++;
    if (last_grant !== 1'b0) begin errors++; $display("FAIL reset_last_grant: got %b want 0", last_grant); end
    checks++;
    if (icache_grant_count !== 16'd0) begin errors++; $display("FAIL reset_icount: got %0d want 0", icache_grant_count); end
    checks++;
    if (dcache_grant_count !== 16'd0) begin errors++; $display("FAIL reset_dcount: got %0d want 0", dcache_grant_count); end
  endtask

  task automatic test_stray_resp();
    int r0;
    r0 = i_resp_n + d_resp_n;
    @(negedge clk);
    stray_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (i_resp_n + d_resp_n !== r0) begin errors++; $display("FAIL stray_resp: got %0d resps want %0d", i_resp_n + d_resp_n, r0); end
    checks++;
    if ({l2_read, l2_write} !== 2'b00) begin errors++; $display("FAIL stray_idle: got strobes %b want 00", {l2_read, l2_write}); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int d0;
    seen = 1'b0;
    d0 = d_resp_n;
    l2_en = 1'b0;
    @(negedge clk);
    push_d(16'h0300, 1'b1, {8{16'h1357}}, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (l2_write) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_grant: got no l2_write want l2_write"); end
    reset = 1'b1;
    d_skip++;
    @(negedge clk);
    reset = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    l2_en = 1'b1;
    checks++;
    if (d_resp_n !== d0) begin errors++; $display("FAIL abort_resp: got %0d dresps want %0d", d_resp_n, d0); end
    checks++;
    if ({l2_read, l2_write} !== 2'b00) begin errors++; $display("FAIL abort_idle: got strobes %b want 00", {l2_read, l2_write}); end
    checks++;
    if (dcache_grant_count !== 16'd0) begin errors++; $display("FAIL abort_dcount: got %0d want 0", dcache_grant_count); end
  endtask

  task automatic test_lone_read();
    int r0;
    int i0;
    int d0;
    lat = 3;
    r0 = rd_cycles; i0 = i_resp_n; d0 = d_resp_n;
    @(negedge clk);
    push_i(16'h1230);
    wait_done("lone_read", 40);
    checks++;
    if (rd_cycles - r0 !== 3) begin errors++; $display("FAIL lone_read_cycles: got %0d want 3", rd_cycles - r0); end
    checks++;
    if (i_resp_n - i0 !== 1 || d_resp_n !== d0) begin
      errors++;
      $display("FAIL lone_resp_pulses: got i=%0d d=%0d want i=1 d=0", i_resp_n - i0, d_resp_n - d0);
    end
    checks++;
    if (icache_grant_count !== 16'd1) begin errors++; $display("FAIL lone_icount: got %0d want 1", icache_grant_count); end
    checks++;
    if (last_grant !== 1'b0) begin errors++; $display("FAIL lone_last_grant: got %b want 0", last_grant); end
  endtask

  task automatic test_tie();
    int r0;
    int w0;
    do_reset();
    lat = 2;
    r0 = rd_cycles; w0 = wr_cycles;
    push_d(16'h0080, 1'b1, {16{8'hA5}}, 1'b1);
    push_i(16'h0040);
    wait_done("tie", 60);
    checks++;
    if (rd_cycles - r0 !== 2 || wr_cycles - w0 !== 2) begin
      errors++;
      $display("FAIL tie_strobe_cycles: got rd=%0d wr=%0d want rd=2 wr=2", rd_cycles - r0, wr_cycles - w0);
    end
    checks++;
    if (last_grant !== 1'b0) begin errors++; $display("FAIL tie_last_grant: got %b want 0", last_grant); end
    checks++;
    if (icache_grant_count !== 16'd1 || dcache_grant_count !== 16'd1) begin
      errors++;
      $display("FAIL tie_counts: got i=%0d d=%0d want 1 1", icache_grant_count, dcache_grant_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      push_d(16'h2000 + 16'(k * 16), k[0], {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      push_i(16'h1000 + 16'(k * 16));
    end
    wait_done("back_to_back", 200);
    checks++;
    if (icache_grant_count !== 16'd4 || dcache_grant_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_counts: got i=%0d d=%0d want 4 4", icache_grant_count, dcache_grant_count);
    end
    checks++;
    if (last_grant !== 1'b0) begin errors++; $display("FAIL b2b_last_grant: got %b want 0", last_grant); end
    checks++;
    if (s_icache_grant_count !== 2'd3 || s_dcache_grant_count !== 2'd3) begin
      errors++;
      $display("FAIL b2b_sat_counts: got i=%0d d=%0d want 3 3", s_icache_grant_count, s_dcache_grant_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    lat = 1;
    for (int k = 0; k < 3; k++) push_i(16'h3000 + 16'(k * 16));
    wait_done("sat_a", 60);
    checks++;
    if (s_icache_grant_count !== 2'd3) begin errors++; $display("FAIL sat_reach_max: got %0d want 3", s_icache_grant_count); end
    for (int k = 0; k < 2; k++) push_i(16'h3100 + 16'(k * 16));
    wait_done("sat_b", 60);
    checks++;
    if (s_icache_grant_count !== 2'd3) begin errors++; $display("FAIL sat_hold_max: got %0d want 3", s_icache_grant_count); end
    checks++;
    if (icache_grant_count !== 16'd5) begin errors++; $display("FAIL sat_wide_count: got %0d want 5", icache_grant_count); end
  endtask

  initial begin
    test_reset();
    test_stray_resp();
    test_reset_abort();
    test_lone_read();
    test_tie();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
